// File: rtl/jht_update_queue.sv
// Coalescing update queue between EXE and the JHT write port (stats counters under JHT_UPDQ_STATS_EN).
// Latency: an update accepted at posedge N reaches the outputs in cycle N+1 at the earliest; no bypass.
// Backpressure: hold freezes the head; when full with no dequeue, non-coalescing updates are dropped.
module jht_update_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              upd_valid,
    input  logic              upd_is_jal,
    input  logic [31:0]       upd_pc,
    input  logic [31:0]       upd_dest,
    input  logic              hold,
    output logic              is_write,
    output logic              is_jal,
    output logic [31:0]       executed_j_pc,
    output logic [31:0]       dest_pc,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  coalesce_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dest;
        logic        is_jal;
        logic        vld;
    } entry_t;

    entry_t           ent_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;

    logic             deq;
    logic             enq;
    logic             hit;
    logic [PTR_W-1:0] hit_idx;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign deq      = ~empty & ~hold;
    assign is_write = deq;

    assign executed_j_pc = empty ? 32'h0 : ent_q[head_q].pc;
    assign dest_pc       = empty ? 32'h0 : ent_q[head_q].dest;
    assign is_jal        = empty ? 1'b0  : ent_q[head_q].is_jal;

    // Descending scan so the lowest matching index wins; the departing head is never a merge target.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (upd_valid && ent_q[i].vld && (ent_q[i].pc == upd_pc) &&
                !(deq && (PTR_W'(i) == head_q))) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    assign enq = upd_valid & ~hit & (~full | deq);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            if (deq) begin
                ent_q[head_q].vld <= 1'b0;
                head_q            <= head_q + PTR_W'(1);
            end
            if (hit) begin
                ent_q[hit_idx].dest   <= upd_dest;
                ent_q[hit_idx].is_jal <= upd_is_jal;
            end
            // When full with a dequeue, tail == head: this write lands after the valid clear above.
            if (enq) begin
                ent_q[tail_q] <= '{pc: upd_pc, dest: upd_dest, is_jal: upd_is_jal, vld: 1'b1};
                tail_q        <= tail_q + PTR_W'(1);
            end
            if (enq && !deq) begin
                count_q <= count_q + (PTR_W+1)'(1);
            end else if (deq && !enq) begin
                count_q <= count_q - (PTR_W+1)'(1);
            end
        end
    end

`ifdef JHT_UPDQ_STATS_EN
    logic             drop;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] coal_cnt_q;

    assign drop = upd_valid & ~hit & full & ~deq;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt_q <= '0;
            coal_cnt_q <= '0;
        end else begin
            if (drop && !(&drop_cnt_q)) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
            if (hit && !(&coal_cnt_q)) begin
                coal_cnt_q <= coal_cnt_q + CNT_W'(1);
            end
        end
    end

    assign drop_cnt     = drop_cnt_q;
    assign coalesce_cnt = coal_cnt_q;
`else
    assign drop_cnt     = '0;
    assign coalesce_cnt = '0;
`endif

endmodule

// File: tb/tb_jht_update_queue.sv
// Directed and random checks of jht_update_queue against a queue-based reference model.
module tb_jht_update_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef JHT_UPDQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk;
    logic              resetn;
    logic              upd_valid;
    logic              upd_is_jal;
    logic [31:0]       upd_pc;
    logic [31:0]       upd_dest;
    logic              hold;
    logic              is_write;
    logic              is_jal;
    logic [31:0]       executed_j_pc;
    logic [31:0]       dest_pc;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  coalesce_cnt;

    jht_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .upd_valid    (upd_valid),
        .upd_is_jal   (upd_is_jal),
        .upd_pc       (upd_pc),
        .upd_dest     (upd_dest),
        .hold         (hold),
        .is_write     (is_write),
        .is_jal       (is_jal),
        .executed_j_pc(executed_j_pc),
        .dest_pc      (dest_pc),
        .empty        (empty),
        .full         (full),
        .drop_cnt     (drop_cnt),
        .coalesce_cnt (coalesce_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] dest;
        logic        jal;
    } ment_t;

    ment_t mq[$];
    int    m_drop;
    int    m_coal;
    int    n_cmp;
    int    n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic ne;
        ne = (mq.size() > 0);
        chk({tag, ".is_write"}, {31'b0, is_write}, {31'b0, ne && !hold});
        chk({tag, ".pc"},       executed_j_pc,     ne ? mq[0].pc : 32'h0);
        chk({tag, ".dest"},     dest_pc,           ne ? mq[0].dest : 32'h0);
        chk({tag, ".is_jal"},   {31'b0, is_jal},   {31'b0, ne ? mq[0].jal : 1'b0});
        chk({tag, ".empty"},    {31'b0, empty},    {31'b0, !ne});
        chk({tag, ".full"},     {31'b0, full},     {31'b0, mq.size() == DEPTH});
        chk({tag, ".drop_cnt"}, 32'(drop_cnt),     STATS ? 32'(m_drop) : 32'h0);
        chk({tag, ".coal_cnt"}, 32'(coalesce_cnt), STATS ? 32'(m_coal) : 32'h0);
    endtask

    // Reference behaviour for one clock edge, using the inputs currently applied.
    task automatic model_edge();
        bit deq;
        int k;
        ment_t e;
        deq = (mq.size() > 0) && !hold;
        k   = -1;
        if (upd_valid) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (k < 0 && mq[i].pc == upd_pc && !(deq && i == 0)) k = i;
            end
            if (k >= 0) begin
                mq[k].dest = upd_dest;
                mq[k].jal  = upd_is_jal;
                if (m_coal < CMAX) m_coal++;
            end else if (mq.size() < DEPTH || deq) begin
                e.pc = upd_pc; e.dest = upd_dest; e.jal = upd_is_jal;
                mq.push_back(e);
            end else if (m_drop < CMAX) begin
                m_drop++;
            end
        end
        if (deq) void'(mq.pop_front());
    endtask

    // Called at a negedge: apply inputs, check outputs, advance model and DUT by one edge.
    task automatic step(input logic v, input logic j, input logic [31:0] pc,
                        input logic [31:0] dest, input logic h, input string tag);
        upd_valid  = v;
        upd_is_jal = j;
        upd_pc     = pc;
        upd_dest   = dest;
        hold       = h;
        #1;
        check_all(tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, h, "idle");
    endtask

    initial begin
        n_cmp = 0; n_err = 0; m_drop = 0; m_coal = 0;
        resetn = 1'b0; upd_valid = 1'b0; upd_is_jal = 1'b0;
        upd_pc = '0; upd_dest = '0; hold = 1'b0;
        @(negedge clk);
        #1;
        check_all("reset");
        resetn = 1'b1;
        @(negedge clk);

        // Single update
        step(1'b1, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b0, "single_in");
        chk("single.pc", executed_j_pc, 32'h8000_0010);
        chk("single.dest", dest_pc, 32'h8000_0100);
        idle(2, 1'b0);
        chk("single.empty_after", {31'b0, empty}, 32'h1);

        // Fill and drop under hold
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 32'h10 * i, 32'h1000 + i, 1'b1, "fill");
            if (i == 4) chk("fill.full_after_4", {31'b0, full}, 32'h1);
        end
        for (int i = 1; i <= 4; i++) begin
            chk("fill.drain_order", executed_j_pc, 32'h10 * i);
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "drain");
        end
        chk("fill.empty_after_drain", {31'b0, empty}, 32'h1);

        // Coalesce
        step(1'b1, 1'b0, 32'h10, 32'hA0, 1'b1, "coal_a");
        step(1'b1, 1'b1, 32'h20, 32'hA4, 1'b1, "coal_b");
        step(1'b1, 1'b1, 32'h10, 32'hB0, 1'b1, "coal_c");
        chk("coal.head_pc", executed_j_pc, 32'h10);
        chk("coal.head_dest", dest_pc, 32'hB0);
        idle(3, 1'b0);

        // Full with simultaneous enqueue and dequeue
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 32'h10 * i, 32'h200 + i, 1'b1, "sim_fill");
        step(1'b1, 1'b1, 32'h60, 32'h600, 1'b0, "sim_enq_deq");
        chk("sim.full_kept", {31'b0, full}, 32'h1);
        chk("sim.head_after", executed_j_pc, 32'h20);
        idle(5, 1'b0);

        // Head-match corner: the departing head is not merged into
        step(1'b1, 1'b0, 32'h10, 32'hA0, 1'b1, "hm_load");
        step(1'b1, 1'b1, 32'h10, 32'hC0, 1'b0, "hm_match");
        chk("hm.pc", executed_j_pc, 32'h10);
        chk("hm.dest", dest_pc, 32'hC0);
        chk("hm.is_write", {31'b0, is_write}, 32'h1);
        idle(2, 1'b0);

        // Random traffic over a small pc set so merges, drops and saturation occur
        for (int n = 0; n < 400; n++) begin
            step(1'b1 & ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                 32'h10 * $urandom_range(1, 6), $urandom, 1'($urandom_range(0, 9) < 5), "rand");
        end
        idle(6, 1'b0);

        // Asynchronous reset mid-cycle with three entries pending
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 32'h100 * i, 32'h300 + i, 1'b1, "rst_fill");
        upd_valid = 1'b0;
        hold      = 1'b0;
        #1;
        check_all("pre_rst");
        resetn = 1'b0;
        #1;
        mq.delete();
        m_drop = 0;
        m_coal = 0;
        check_all("async_rst");
        #1;
        resetn = 1'b1;
        @(negedge clk);
        step(1'b1, 1'b0, 32'h44, 32'h88, 1'b0, "post_rst");
        idle(2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
